mult_scheduler: RTL and testbench

Sequencer and two-port arbiter for the shift-add multiplier. It accepts multiply requests from two requesters (port 0: integer pipeline MULT; port 1: address/auxiliary unit) and grants the shared multiplier round-robin. It drives the multiplier controller's start and bit-count-complete inputs, captures the product and returns it with a requester tag. It sits between the requesters and the multiplier datapath/CONTROL pair, and owns the only start path into them.

---
 rtl/mult_scheduler.sv | 150 +++++++++++++++
 tb/tb_mult_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin two-port sequencer and start path for the shift-add multiplier.
// Optional macro MULT_SCHED_WATCHDOG_EN aborts BUSY after 2*WIDTH+TMO_SLACK cycles without mul_done.
module mult_scheduler #(
    parameter int WIDTH     = 16,
    parameter int TMO_SLACK = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic [WIDTH-1:0]   a0_i,
    input  logic [WIDTH-1:0]   b0_i,
    input  logic [WIDTH-1:0]   a1_i,
    input  logic [WIDTH-1:0]   b1_i,
    output logic               gnt0_o,
    output logic               gnt1_o,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [2*WIDTH-1:0] rsp_prod_o,
    output logic               rsp_err_o,
    output logic [WIDTH-1:0]   mul_a_o,
    output logic [WIDTH-1:0]   mul_b_o,
    output logic               mul_st_o,
    output logic               mul_k_o,
    input  logic               mul_sh_i,
    input  logic               mul_done_i,
    input  logic [2*WIDTH-1:0] mul_prod_i,
    output logic               mul_abort_o
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 32 || TMO_SLACK < 1) begin : g_bad_param
        $error("mult_scheduler: illegal WIDTH or TMO_SLACK");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d, id_q, id_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d, st_q, st_d;
    logic               valid_q, valid_d, err_q, err_d, abort_q, abort_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               win, timeout;

    // ptr_q is the last-served port; with both requesting the other one wins
    assign win = req1_i & (~req0_i | ~ptr_q);

`ifdef MULT_SCHED_WATCHDOG_EN
    localparam int TMO = 2 * WIDTH + TMO_SLACK;
    localparam int TW  = $clog2(TMO + 1);
    logic [TW-1:0] wd_q;
    always_ff @(posedge clk_i)
        wd_q <= (!reset_n_i || state_q != BUSY) ? '0 : wd_q + 1'b1;
    assign timeout = (state_q == BUSY) && !mul_done_i && (wd_q == TW'(TMO - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        st_d    = 1'b0;
        abort_d = timeout;
        case (state_q)
            IDLE: if (req0_i || req1_i) begin
                state_d = ISSUE;
                ptr_d   = win;
                id_d    = win;
                a_d     = win ? a1_i : a0_i;
                b_d     = win ? b1_i : b0_i;
                cnt_d   = '0;
                gnt0_d  = ~win;
                gnt1_d  = win;
                st_d    = 1'b1;
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (mul_sh_i && cnt_q != CW'(WIDTH - 1))
                    cnt_d = cnt_q + 1'b1;
                if (mul_done_i) begin
                    state_d = RESP;
                    prod_d  = mul_prod_i;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d = RESP;
                    prod_d  = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            st_q    <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            st_q    <= st_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign rsp_valid_o = valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_prod_o  = prod_q;
    assign rsp_err_o   = err_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign mul_st_o    = st_q;
    assign mul_abort_o = abort_q;
    assign mul_k_o     = (state_q == BUSY) && (cnt_q == CW'(WIDTH - 1));
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed/randomized bench for mult_scheduler with a behavioural
// multiply-controller model (add/shift alternation, done after 2*W cycles, product a*b).
module tb_mult_scheduler;
    localparam int W   = 16;
    localparam int LAT = 2 * W + 3;

    logic           clk = 1'b0;
    logic           reset_n, req0, req1, rsp_ready;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, rsp_valid, rsp_id, rsp_err;
    logic [2*W-1:0] rsp_prod, mul_prod;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_st, mul_k, mul_sh, mul_done, mul_abort;
    logic           spur = 1'b0;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    mult_scheduler #(.WIDTH(W), .TMO_SLACK(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req0_i(req0), .req1_i(req1),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_prod_o(rsp_prod), .rsp_err_o(rsp_err),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_st_o(mul_st), .mul_k_o(mul_k),
        .mul_sh_i(mul_sh), .mul_done_i(mul_done), .mul_prod_i(mul_prod),
        .mul_abort_o(mul_abort)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model: phase 1..2W alternates add-check/shift, phase 2W+1 is done.
    // Outside an operation it may inject junk strobes that the scheduler must ignore.
    initial begin : ctl
        int ph;
        logic go;
        logic [2*W-1:0] p;
        ph = 0; go = 1'b0; p = '0;
        mul_sh = 1'b0; mul_done = 1'b0; mul_prod = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mul_abort === 1'b1) ph = 0;
            else if (ph != 0) ph = (ph == 2 * W + 1) ? 0 : ph + 1;
            else if (go) ph = 1;
            go = (mul_st === 1'b1) && (mul_abort !== 1'b1);
            if (go) p = 32'(mul_a) * 32'(mul_b);
            if (ph == 0) begin
                mul_sh   = spur && ($urandom_range(0, 1) == 1);
                mul_done = spur && ($urandom_range(0, 1) == 1);
                mul_prod = $urandom;
            end else begin
                mul_sh   = (ph <= 2 * W) && (ph % 2 == 0);
                mul_done = (ph == 2 * W + 1);
                mul_prod = (ph == 2 * W + 1) ? p : $urandom;
            end
        end
    end

    task automatic wait_grant(output int port, output int cyc);
        port = -1;
        cyc  = 0;
        while (port < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (gnt0 === 1'b1) port = 0;
            else if (gnt1 === 1'b1) port = 1;
        end
        chk("grant_seen", 64'(port >= 0), 64'd1);
        chk("grant_onehot", 64'({gnt0, gnt1}), (port == 1) ? 64'b01 : 64'b10);
    endtask

    task automatic wait_rsp(output int cyc, output logic [15:0] kmask, output int np);
        int nsh;
        nsh = 0; cyc = 0; kmask = '0; np = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mul_st === 1'b1 || gnt0 === 1'b1 || gnt1 === 1'b1) np++;
            if (mul_sh === 1'b1 && !spur) begin
                if (nsh < 16) kmask[nsh[3:0]] = mul_k;
                nsh++;
            end
        end
    endtask

    task automatic take_rsp(input int hold, output logic stable);
        logic [2*W-1:0] p0;
        logic i0;
        p0 = rsp_prod; i0 = rsp_id; stable = 1'b1;
        rsp_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_prod !== p0 || rsp_id !== i0 || gnt0 !== 1'b0 || gnt1 !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int port, gc, rc, np, last, ng, hold;
        logic [15:0] km;
        logic st;
        logic [W-1:0] ea, eb;
        logic [2*W-1:0] ep;
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({gnt0, gnt1, rsp_valid, rsp_id, rsp_err, mul_st, mul_k, mul_abort}), 64'b0000_0001);
        chk("rst_prod", 64'(rsp_prod), 64'd0);
        chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // single request on port 0
        a0 = 16'd3; b0 = 16'd7; req0 = 1'b1;
        wait_grant(port, gc);
        req0 = 1'b0;
        chk("t1_port", 64'(port), 64'd0);
        chk("t1_gnt_delay", 64'(gc), 64'd1);
        chk("t1_issue", 64'({mul_st, mul_abort, mul_a, mul_b}), 64'({1'b1, 1'b0, 16'd3, 16'd7}));
        wait_rsp(rc, km, np);
        chk("t1_latency", 64'(gc + rc), 64'(LAT));
        chk("t1_k_on_16th_shift", 64'(km), 64'h8000);
        chk("t1_single_pulse", 64'(np), 64'd0);
        chk("t1_rsp", 64'({rsp_err, rsp_id, rsp_prod}), 64'({1'b0, 1'b0, 32'd21}));
        // req1 raised and dropped while waiting in RESP must never be granted
        rsp_ready = 1'b0; req1 = 1'b1; a1 = 16'd5; b1 = 16'd5;
        repeat (2) @(negedge clk);
        req1 = 1'b0; rsp_ready = 1'b1;
        ng = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt0 === 1'b1 || gnt1 === 1'b1 || rsp_valid === 1'b1) ng++;
        end
        chk("dropped_req_quiet", 64'(ng), 64'd0);

        // both requesting straight out of reset
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        a0 = 16'hFFFF; b0 = 16'hFFFF; a1 = 16'd2; b1 = 16'd5; req0 = 1'b1; req1 = 1'b1;
        wait_grant(port, gc);
        req0 = 1'b0;
        chk("t2_first_port", 64'(port), 64'd0);
        wait_rsp(rc, km, np);
        chk("t2_rsp0", 64'({rsp_id, rsp_prod}), 64'({1'b0, 32'hFFFE0001}));
        take_rsp(0, st);
        wait_grant(port, gc);
        req1 = 1'b0;
        chk("t2_second_port", 64'(port), 64'd1);
        chk("t2_gnt_after_accept", 64'(gc), 64'd1);
        wait_rsp(rc, km, np);
        chk("t2_rsp1", 64'({rsp_id, rsp_prod}), 64'({1'b1, 32'd10}));
        take_rsp(0, st);

        // both held continuously: strict alternation, random operands, junk strobes
        spur = 1'b1; last = 1;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_grant(port, gc);
            chk("rr_port", 64'(port), 64'(1 - last));
            chk("rr_gnt_delay", 64'(gc), 64'd1);
            ea = (port == 1) ? a1 : a0;
            eb = (port == 1) ? b1 : b0;
            ep = 32'(ea) * 32'(eb);
            chk("rr_operands", 64'({mul_a, mul_b}), 64'({ea, eb}));
            if (port == 1) begin a1 = W'($urandom); b1 = W'($urandom); end
            else begin a0 = W'($urandom); b0 = W'($urandom); end
            last = port;
            wait_rsp(rc, km, np);
            chk("rr_latency", 64'(gc + rc), 64'(LAT));
            chk("rr_no_extra_gnt", 64'(np), 64'd0);
            chk("rr_rsp", 64'({rsp_err, rsp_id, rsp_prod}), 64'({1'b0, port[0], ep}));
            if (i == 7) begin req0 = 1'b0; req1 = 1'b0; end
            hold = (i == 3) ? 10 : $urandom_range(0, 3);
            take_rsp(hold, st);
            chk("rr_rsp_stable", 64'(st), 64'd1);
        end

        // reset pulse mid-BUSY after serving port 0: pointer must return to 1
        a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
        wait_grant(port, gc);
        req0 = 1'b0;
        chk("t5_pre_port", 64'(port), 64'd0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_after_reset", 64'({rsp_valid, mul_abort, gnt0, gnt1, mul_st, mul_k}), 64'b010000);
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        ep = 32'(a0) * 32'(b0);
        req0 = 1'b1; req1 = 1'b1;
        wait_grant(port, gc);
        req0 = 1'b0;
        chk("t5_port", 64'(port), 64'd0);
        chk("t5_idle_after_reset", 64'(gc), 64'd1);
        chk("t5_abort_released", 64'(mul_abort), 64'd0);
        wait_rsp(rc, km, np);
        chk("t5_latency", 64'(gc + rc), 64'(LAT));
        chk("t5_rsp", 64'({rsp_err, rsp_id, rsp_prod}), 64'({1'b0, 1'b0, ep}));
        ep = 32'(a1) * 32'(b1);
        take_rsp(1, st);
        wait_grant(port, gc);
        req1 = 1'b0;
        chk("t5_next_port", 64'(port), 64'd1);
        wait_rsp(rc, km, np);
        chk("t5_rsp1", 64'({rsp_id, rsp_prod}), 64'({1'b1, ep}));
        take_rsp(0, st);
        ng = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || gnt0 === 1'b1 || gnt1 === 1'b1) ng++;
        end
        chk("final_quiet", 64'(ng), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
